// File: rtl/hex_overlay_pkg.sv
// Shared widths and the nibble-select helper for the hex overlay.
package hex_overlay_pkg;

    localparam int CHAR_W     = 7;
    localparam int NIB_W      = 4;
    // Widest field value the helper accepts, in hex digits.
    localparam int MAX_DIGITS = 16;

    // Returns the d-th displayed nibble of a field (d=0 is the leftmost, most
    // significant digit). Out-of-field offsets return zero.
    function automatic logic [NIB_W-1:0] nib_sel(
        input logic [NIB_W*MAX_DIGITS-1:0] value,
        input int unsigned                 digits,
        input logic [CHAR_W-1:0]           d
    );
        int unsigned di;
        di = 32'(d);
        if (di >= digits) begin
            return '0;
        end
        return value[NIB_W*(digits-1-di) +: NIB_W];
    endfunction

endpackage

// File: rtl/hex_field_match.sv
// Combinational hit test and nibble pick for one positioned hex field.
module hex_field_match
    import hex_overlay_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  en_i,
    input  logic [CHAR_W-1:0]     x_i,
    input  logic [CHAR_W-1:0]     y_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [CHAR_W-1:0]     char_x_i,
    input  logic [CHAR_W-1:0]     char_y_i,
    output logic                  match_o,
    output logic [NIB_W-1:0]      nib_o
);

    logic [CHAR_W:0]   end_x;
    logic [CHAR_W-1:0] d;

    // Field extent is computed one bit wider so a field near column 127 is clipped, not wrapped.
    always_comb begin
        end_x   = {1'b0, x_i} + (CHAR_W+1)'(DIGITS);
        d       = char_x_i - x_i;
        match_o = en_i && (char_y_i == y_i) && (char_x_i >= x_i)
                  && ({1'b0, char_x_i} < end_x);
        nib_o   = nib_sel((NIB_W*MAX_DIGITS)'(value_i), DIGITS, d);
    end

endmodule

// File: rtl/hex_overlay.sv
// Hex-field overlay: maps font-engine character cells to hex digit glyph bits,
// with a pending field table that is copied to the active table at vsync rise.
module hex_overlay
    import hex_overlay_pkg::*;
#(
    parameter  int NUM_FIELDS = 4,
    parameter  int DIGITS     = 8,
    localparam int AW         = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blank,
    input  logic                  vsync,
    input  logic [CHAR_W-1:0]     char_x,
    input  logic [CHAR_W-1:0]     char_y,
    input  logic [15:0]           char_data,
    input  logic                  wr_en,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  wr_field_en,
    input  logic [CHAR_W-1:0]     wr_x,
    input  logic [CHAR_W-1:0]     wr_y,
    input  logic [4*DIGITS-1:0]   wr_value,
    output logic                  hit,
    output logic                  pixel
);

    typedef struct packed {
        logic                en;
        logic [CHAR_W-1:0]   x;
        logic [CHAR_W-1:0]   y;
        logic [4*DIGITS-1:0] value;
    } field_t;

    field_t            pend_q [NUM_FIELDS];
    field_t            act_q  [NUM_FIELDS];
    logic              vsync_d1_q;
    logic              vsync_rise;
    logic              wr_in_range;

    logic              match [NUM_FIELDS];
    logic [NIB_W-1:0]  nib   [NUM_FIELDS];

    logic              sel_hit_d, sel_hit_q;
    logic [NIB_W-1:0]  sel_nib_d, sel_nib_q;
    logic              blank_s1_q;
    logic              hit_q, pixel_q;

    assign vsync_rise  = vsync && !vsync_d1_q;
    assign wr_ready    = !reset && !vsync_rise;
    assign wr_in_range = 32'(wr_addr) < NUM_FIELDS;
    assign hit         = hit_q;
    assign pixel       = pixel_q;

    // Field tables: writes land in pending; pending snapshots into active at vsync rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            vsync_d1_q <= 1'b0;
        end else begin
            vsync_d1_q <= vsync;
            if (vsync_rise) begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    act_q[i] <= pend_q[i];
                end
            end
            if (wr_en && wr_ready && wr_in_range) begin
                pend_q[wr_addr] <= '{en: wr_field_en, x: wr_x, y: wr_y, value: wr_value};
            end
        end
    end

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        hex_field_match #(
            .DIGITS (DIGITS)
        ) u_match (
            .en_i     (act_q[g].en),
            .x_i      (act_q[g].x),
            .y_i      (act_q[g].y),
            .value_i  (act_q[g].value),
            .char_x_i (char_x),
            .char_y_i (char_y),
            .match_o  (match[g]),
            .nib_o    (nib[g])
        );
    end

    // Priority select: the lowest-numbered matching field owns the cell.
    always_comb begin
        sel_hit_d = 1'b0;
        sel_nib_d = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_hit_d = 1'b1;
                sel_nib_d = nib[i];
            end
        end
    end

    // Stage 1 and stage 2 control; stage 2 meets char_data one cycle after its coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_hit_q  <= 1'b0;
            blank_s1_q <= 1'b0;
            hit_q      <= 1'b0;
            pixel_q    <= 1'b0;
        end else begin
            sel_hit_q  <= sel_hit_d;
            blank_s1_q <= blank;
            hit_q      <= sel_hit_q && !blank_s1_q;
            pixel_q    <= sel_hit_q && !blank_s1_q && char_data[sel_nib_q];
        end
    end

    // Stage 1 nibble index is only meaningful alongside sel_hit_q, so it carries no reset.
    always_ff @(posedge clk) begin
        sel_nib_q <= sel_nib_d;
    end

endmodule

// File: tb/tb_hex_overlay.sv
// Directed bench for hex_overlay with a field-table reference model.
module tb_hex_overlay;

    localparam int NF = 4;
    localparam int DG = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b0;
    logic        vsync = 1'b0;
    logic [6:0]  char_x = '0;
    logic [6:0]  char_y = '0;
    logic [15:0] char_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_addr = '0;
    logic        wr_field_en = 1'b0;
    logic [6:0]  wr_x = '0;
    logic [6:0]  wr_y = '0;
    logic [31:0] wr_value = '0;
    logic        hit;
    logic        pixel;

    always #5 clk = ~clk;

    hex_overlay #(
        .NUM_FIELDS (NF),
        .DIGITS     (DG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .blank       (blank),
        .vsync       (vsync),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_data   (char_data),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_field_en (wr_field_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_value    (wr_value),
        .hit         (hit),
        .pixel       (pixel)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: tables as plain records, cell lookup by column arithmetic.
    typedef struct {
        bit          en;
        int          x;
        int          y;
        logic [31:0] v;
    } fld_t;

    fld_t pend [NF];
    fld_t act  [NF];
    bit   m_vs_d   = 1'b0;
    bit   s1_hit   = 1'b0;
    bit   s1_blank = 1'b0;
    int   s1_nib   = 0;
    bit   exp_hit  = 1'b0;
    bit   exp_pix  = 1'b0;

    always @(posedge clk) begin
        bit rise;
        bit fh;
        int fn;
        int cx;
        int cy;
        if (reset) begin
            exp_hit = 1'b0;
            exp_pix = 1'b0;
        end else begin
            exp_hit = s1_hit && !s1_blank;
            exp_pix = exp_hit && (char_data[s1_nib] == 1'b1);
        end
        cx = int'(char_x);
        cy = int'(char_y);
        fh = 1'b0;
        fn = 0;
        for (int i = 0; i < NF; i++) begin
            if (!fh && act[i].en && act[i].y == cy && cx >= act[i].x && cx < act[i].x + DG) begin
                fh = 1'b1;
                fn = int'((act[i].v >> (4 * (DG - 1 - (cx - act[i].x)))) & 32'hF);
            end
        end
        s1_hit   = reset ? 1'b0 : fh;
        s1_nib   = fn;
        s1_blank = blank;
        rise = vsync && !m_vs_d;
        if (reset) begin
            for (int i = 0; i < NF; i++) begin
                pend[i] = '{1'b0, 0, 0, 32'h0};
                act[i]  = '{1'b0, 0, 0, 32'h0};
            end
            m_vs_d = 1'b0;
        end else begin
            if (rise) act = pend;
            if (wr_en && !rise && int'(wr_addr) < NF)
                pend[wr_addr] = '{wr_field_en, int'(wr_x), int'(wr_y), wr_value};
            m_vs_d = vsync;
        end
    end

    // Every-cycle comparison of the outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_hit", hit, exp_hit);
            chk("m_pixel", pixel, exp_pix);
            chk("m_wr_ready", wr_ready, !reset && !(vsync && !m_vs_d));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        cyc();
        vsync = 1'b0;
        cyc();
    endtask

    task automatic wr(input int a, input bit e, input int x, input int y, input logic [31:0] v);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_field_en = e;
        wr_x = 7'(x);
        wr_y = 7'(y);
        wr_value = v;
        cyc();
        wr_en = 1'b0;
    endtask

    // Present one cell, then its glyph vector; check the 2-cycle coordinate latency.
    task automatic probe(input string nm, input int cx, input int cy, input bit bl,
                         input logic [15:0] cd, input bit eh, input bit ep);
        char_x = 7'(cx);
        char_y = 7'(cy);
        blank = bl;
        char_data = 16'h0;
        cyc();
        #4 chk({nm, "_lat1"}, hit, 1'b0);
        char_x = '0;
        char_y = '0;
        blank = 1'b0;
        char_data = cd;
        cyc();
        #4;
        chk({nm, "_hit"}, hit, eh);
        chk({nm, "_pix"}, pixel, ep);
        char_data = 16'h0;
        cyc();
    endtask

    initial begin
        // 1: reset, then a frame of cells with every glyph bit set and no fields
        reset = 1'b1;
        cyc();
        chk_en = 1'b1;
        #4;
        chk("rst_hit", hit, 1'b0);
        chk("rst_pixel", pixel, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();
        vs_pulse();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 128; x++) begin
                char_x = 7'(x);
                char_y = 7'(y);
                char_data = 16'hFFFF;
                cyc();
            end
        end
        char_x = '0;
        char_y = '0;
        char_data = '0;
        cyc();
        cyc();

        // 2: a pending write is invisible until vsync rises
        wr(0, 1'b1, 10, 2, 32'h0123ABCD);
        probe("pre_vs", 10, 2, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        vs_pulse();
        probe("x10_b0", 10, 2, 1'b0, 16'h0001, 1'b1, 1'b1);
        probe("x10_nb0", 10, 2, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        probe("x17_b13", 17, 2, 1'b0, 16'h2000, 1'b1, 1'b1);
        probe("x17_nb13", 17, 2, 1'b0, 16'hDFFF, 1'b1, 1'b0);
        probe("x18_out", 18, 2, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // 3: overlapping fields, lowest index wins
        wr(1, 1'b1, 12, 2, 32'hFFFFFFFF);
        vs_pulse();
        probe("ovl_b2", 12, 2, 1'b0, 16'h0004, 1'b1, 1'b1);
        probe("ovl_bF", 12, 2, 1'b0, 16'h8000, 1'b1, 1'b0);
        probe("f1_only", 18, 2, 1'b0, 16'h8000, 1'b1, 1'b1);

        // 4: a write presented in the vsync-rise cycle is dropped
        vsync = 1'b1;
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_field_en = 1'b1;
        wr_x = 7'd10;
        wr_y = 7'd2;
        wr_value = 32'hFFFFFFFF;
        #4 chk("rise_wr_ready", wr_ready, 1'b0);
        cyc();
        vsync = 1'b0;
        wr_en = 1'b0;
        cyc();
        vs_pulse();
        probe("lost_b0", 10, 2, 1'b0, 16'h0001, 1'b1, 1'b1);
        probe("lost_bF", 10, 2, 1'b0, 16'h8000, 1'b1, 1'b0);

        // 5: field clipped at the right edge of the row
        wr(2, 1'b1, 124, 5, 32'h89ABCDEF);
        vs_pulse();
        probe("x124", 124, 5, 1'b0, 16'h0100, 1'b1, 1'b1);
        probe("x125", 125, 5, 1'b0, 16'h0200, 1'b1, 1'b1);
        probe("x127", 127, 5, 1'b0, 16'h0800, 1'b1, 1'b1);
        probe("x127_n", 127, 5, 1'b0, 16'hF7FF, 1'b1, 1'b0);
        probe("x0_nowrap", 0, 5, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        probe("x3_nowrap", 3, 5, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // 6: blanking, then reset in the middle of visible fields
        probe("blank", 10, 2, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        char_x = 7'd10;
        char_y = 7'd2;
        char_data = 16'h0001;
        cyc();
        cyc();
        cyc();
        #4 chk("pre_rst_pix", pixel, 1'b1);
        reset = 1'b1;
        cyc();
        #4 chk("rst_mid_pix", pixel, 1'b0);
        reset = 1'b0;
        cyc();
        #4 chk("rst_next_pix", pixel, 1'b0);
        cyc();
        #4 chk("rst_next2_pix", pixel, 1'b0);
        char_x = '0;
        char_y = '0;
        char_data = '0;
        cyc();
        vs_pulse();
        probe("post_rst", 10, 2, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        vs_pulse();
        probe("post_rst2", 124, 5, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        wr(0, 1'b1, 10, 2, 32'h0123ABCD);
        vs_pulse();
        probe("rewrite", 10, 2, 1'b0, 16'h0001, 1'b1, 1'b1);

        cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
